clock_uart_reporter: RTL and testbench

CLOCK_UART_REPORTER -- requirements
Module: clock_uart_reporter

---
 rtl/clock_uart_reporter_if.sv | 22 ++
 rtl/clock_uart_reporter.sv | 180 ++++++++++++++++++
 tb/tb_clock_uart_reporter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_uart_reporter_if.sv
// ---------------------------------------------------------------------------
// clock_uart_reporter_if
// Request/response bundle for clock_uart_reporter.
//   send      : single-cycle request to transmit one timestamp frame
//   time_bcd  : {h_t,h_o,m_t,m_o,s_t,s_o}, 4 bits per digit, MSB-first
//   date_bcd  : {d_t,d_o,mo_t,mo_o,y_th,y_hu,y_te,y_on}, 4 bits per digit
//   tx        : UART serial line, 8N1, idle high
//   busy      : high while a frame is in progress
//   done      : one-cycle pulse when a frame completes
// master = requester side, slave = the reporter.
// ---------------------------------------------------------------------------
interface clock_uart_reporter_if;
  logic        send;
  logic [23:0] time_bcd;
  logic [31:0] date_bcd;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (output send, time_bcd, date_bcd, input tx, busy, done);
  modport slave  (input send, time_bcd, date_bcd, output tx, busy, done);
endinterface

// File: rtl/clock_uart_reporter.sv
// ---------------------------------------------------------------------------
// clock_uart_reporter
// Transmits a 21-character ASCII timestamp "HH:MM:SS DD/MM/YYYY\r\n" over an
// 8N1 UART when requested. Digits above 9 are sent as '?'.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset (aborts any frame, tx forced high)
//   bus : clock_uart_reporter_if.slave (send/time_bcd/date_bcd in,
//         tx/busy/done out)
// Parameters: CLK_HZ, BAUD; bit period BAUD_DIV = CLK_HZ/BAUD (must be >= 2).
// ---------------------------------------------------------------------------
module clock_uart_reporter #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic                  clk,
  input  logic                  rst,
  clock_uart_reporter_if.slave  bus
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [4:0] LAST_CHAR = 5'd20;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_baud, w_baud;
  logic [2:0]       r_bit, w_bit;
  logic [4:0]       r_char, w_char;
  logic [23:0]      r_time, w_time;
  logic [31:0]      r_date, w_date;
  logic             r_tx, w_tx;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             w_bit_end;
  logic [7:0]       w_byte;

  function automatic logic [7:0] digit_ascii(input logic [3:0] v);
    return (v <= 4'd9) ? (8'h30 + {4'h0, v}) : 8'h3F;
  endfunction

  // Character at position idx of the frame, from the snapshot registers.
  function automatic logic [7:0] frame_char(input logic [4:0]  idx,
                                            input logic [23:0] t,
                                            input logic [31:0] d);
    case (idx)
      5'd0:  return digit_ascii(t[23:20]);
      5'd1:  return digit_ascii(t[19:16]);
      5'd2:  return 8'h3A;
      5'd3:  return digit_ascii(t[15:12]);
      5'd4:  return digit_ascii(t[11:8]);
      5'd5:  return 8'h3A;
      5'd6:  return digit_ascii(t[7:4]);
      5'd7:  return digit_ascii(t[3:0]);
      5'd8:  return 8'h20;
      5'd9:  return digit_ascii(d[31:28]);
      5'd10: return digit_ascii(d[27:24]);
      5'd11: return 8'h2F;
      5'd12: return digit_ascii(d[23:20]);
      5'd13: return digit_ascii(d[19:16]);
      5'd14: return 8'h2F;
      5'd15: return digit_ascii(d[15:12]);
      5'd16: return digit_ascii(d[11:8]);
      5'd17: return digit_ascii(d[7:4]);
      5'd18: return digit_ascii(d[3:0]);
      5'd19: return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  assign w_bit_end = (r_baud == BAUD_LAST);
  assign w_byte    = frame_char(r_char, r_time, r_date);

  // tx is computed one cycle ahead here and registered, so the line level
  // changes exactly on the bit-boundary edge and comes straight from a flop.
  always_comb begin
    w_state = r_state;
    w_baud  = r_baud;
    w_bit   = r_bit;
    w_char  = r_char;
    w_time  = r_time;
    w_date  = r_date;
    w_tx    = r_tx;
    w_busy  = r_busy;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx   = 1'b1;
        w_busy = 1'b0;
        w_baud = '0;
        w_bit  = '0;
        w_char = '0;
        if (bus.send) begin
          w_state = START;
          w_time  = bus.time_bcd;
          w_date  = bus.date_bcd;
          w_tx    = 1'b0;
          w_busy  = 1'b1;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_baud  = '0;
          w_state = DATA;
          w_bit   = '0;
          w_tx    = w_byte[0];
        end else begin
          w_baud = r_baud + 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud = '0;
          if (r_bit == 3'd7) begin
            w_state = STOP;
            w_bit   = '0;
            w_tx    = 1'b1;
          end else begin
            w_bit = r_bit + 3'd1;
            w_tx  = w_byte[r_bit + 3'd1];
          end
        end else begin
          w_baud = r_baud + 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_baud = '0;
          if (r_char == LAST_CHAR) begin
            // Busy drops on this edge, so a send seen in the done cycle
            // is accepted from IDLE on the very next edge.
            w_state = IDLE;
            w_char  = '0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_tx    = 1'b1;
          end else begin
            w_state = START;
            w_char  = r_char + 5'd1;
            w_tx    = 1'b0;
          end
        end else begin
          w_baud = r_baud + 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_char  <= '0;
      r_time  <= '0;
      r_date  <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_bit   <= w_bit;
      r_char  <= w_char;
      r_time  <= w_time;
      r_date  <= w_date;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign bus.tx   = r_tx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_clock_uart_reporter.sv
// ---------------------------------------------------------------------------
// tb_clock_uart_reporter
// Self-checking bench for clock_uart_reporter with CLK_HZ=8, BAUD=1
// (8 cycles per bit). Each log index k holds the outputs seen just after
// the k-th rising edge counted from the edge that accepted send (k=0).
// ---------------------------------------------------------------------------
module tb_clock_uart_reporter;
  localparam int CLK_HZ = 8;
  localparam int BAUD   = 1;
  localparam int BD     = 8;
  localparam int CHAR_C = 10 * BD;
  localparam int FRAME  = 21 * CHAR_C;
  localparam int LOG_N  = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clock_uart_reporter_if bus ();

  clock_uart_reporter #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic        tx_log   [0:LOG_N-1];
  logic        busy_log [0:LOG_N-1];
  logic        done_log [0:LOG_N-1];
  logic [7:0]  exp_bytes [0:20];
  logic [7:0]  dec_bytes [0:20];
  logic [23:0] nt;
  logic [31:0] nd;
  int n_checks = 0;
  int n_pass   = 0;

  // Reference frame: fill a text template, one BCD digit per marker letter.
  function automatic logic [7:0] ascii_of(input int v);
    return (v < 10) ? 8'(8'h30 + v) : 8'h3F;
  endfunction

  function automatic void build_exp(input logic [23:0] t, input logic [31:0] d);
    string tpl;
    int ti, di, n;
    tpl = "tt:tt:tt dd/dd/dddd";
    ti = 0; di = 0; n = 0;
    for (int i = 0; i < tpl.len(); i++) begin
      if (tpl[i] == "t") begin
        exp_bytes[n] = ascii_of(int'((t >> (20 - 4 * ti)) & 24'hF));
        ti++;
      end else if (tpl[i] == "d") begin
        exp_bytes[n] = ascii_of(int'((d >> (28 - 4 * di)) & 32'hF));
        di++;
      end else begin
        exp_bytes[n] = tpl[i];
      end
      n++;
    end
    exp_bytes[19] = 8'h0D;
    exp_bytes[20] = 8'h0A;
  endfunction

  // Cycle-exact comparison of the logged line against an ideal 8N1 stream.
  function automatic int wave_errs(input int base, input logic [23:0] t, input logic [31:0] d);
    int errs, c, p;
    logic e;
    build_exp(t, d);
    errs = 0;
    for (int i = 0; i < FRAME; i++) begin
      c = i / CHAR_C;
      p = (i % CHAR_C) / BD;
      if (p == 0)      e = 1'b0;
      else if (p == 9) e = 1'b1;
      else             e = exp_bytes[c][p-1];
      if (tx_log[base + i] !== e) errs++;
    end
    if (tx_log[base + FRAME] !== 1'b1) errs++;
    return errs;
  endfunction

  // Mid-bit sampling decoder, like a UART receiver would do.
  function automatic void decode(input int base);
    for (int c = 0; c < 21; c++)
      for (int b = 0; b < 8; b++)
        dec_bytes[c][b] = tx_log[base + c * CHAR_C + (b + 1) * BD + BD / 2];
  endfunction

  function automatic int decode_errs(input int base, input logic [23:0] t, input logic [31:0] d);
    int errs;
    build_exp(t, d);
    decode(base);
    errs = 0;
    for (int c = 0; c < 21; c++) if (dec_bytes[c] !== exp_bytes[c]) errs++;
    return errs;
  endfunction

  function automatic int count_busy(input int from, input int to);
    int n = 0;
    for (int i = from; i <= to; i++) if (busy_log[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_done(input int from, input int to);
    int n = 0;
    for (int i = from; i <= to; i++) if (done_log[i] === 1'b1) n++;
    return n;
  endfunction

  // Logs n samples; after sample chg_at the inputs become nt/nd, and send
  // is held high only for the edge following sample resend_at.
  task automatic capture(input int base, input int n, input int resend_at, input int chg_at);
    for (int k = base; k < base + n; k++) begin
      @(posedge clk);
      #1;
      tx_log[k]   = bus.tx;
      busy_log[k] = bus.busy;
      done_log[k] = bus.done;
      bus.send = (k == resend_at);
      if (k == chg_at) begin
        bus.time_bcd = nt;
        bus.date_bcd = nd;
      end
    end
  endtask

  task automatic start_frame(input logic [23:0] t, input logic [31:0] d);
    @(negedge clk);
    bus.time_bcd = t;
    bus.date_bcd = d;
    bus.send     = 1'b1;
  endtask

  task automatic idle_gap();
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [3:0] rnd_digit();
    return 4'($urandom_range(0, 11));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.send = 1'b0;
    bus.time_bcd = 24'h123456;
    bus.date_bcd = 32'h01022023;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.tx !== 1'b1) $display("FAIL reset_tx got=%b exp=1", bus.tx); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else n_pass++;
    // Release and request in the same cycle: first following edge accepts.
    rst = 1'b0;
    bus.send = 1'b1;
    @(posedge clk);
    #1;
    bus.send = 1'b0;
    n_checks++; if (bus.busy !== 1'b1 || bus.tx !== 1'b0)
      $display("FAIL reset_first_accept got busy=%b tx=%b exp busy=1 tx=0", bus.busy, bus.tx); else n_pass++;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    idle_gap();
  endtask

  task automatic test_basic();
    int e;
    start_frame(24'h235959, 32'h31122024);
    capture(0, FRAME + 10, -1, -1);
    build_exp(24'h235959, 32'h31122024);
    decode(0);
    for (int c = 0; c < 21; c++) begin
      n_checks++;
      if (dec_bytes[c] !== exp_bytes[c])
        $display("FAIL basic_char%0d got=%h exp=%h", c, dec_bytes[c], exp_bytes[c]);
      else n_pass++;
    end
    e = wave_errs(0, 24'h235959, 32'h31122024);
    n_checks++; if (e !== 0) $display("FAIL basic_wave bad_cycles=%0d exp=0", e); else n_pass++;
    e = count_busy(0, FRAME + 9);
    n_checks++; if (e !== FRAME) $display("FAIL basic_busy_len got=%0d exp=%0d", e, FRAME); else n_pass++;
    n_checks++; if (busy_log[FRAME-1] !== 1'b1 || busy_log[FRAME] !== 1'b0)
      $display("FAIL basic_busy_fall got=%b%b exp=10", busy_log[FRAME-1], busy_log[FRAME]); else n_pass++;
    n_checks++; if (done_log[FRAME] !== 1'b1) $display("FAIL basic_done_pos got=%b exp=1", done_log[FRAME]); else n_pass++;
    e = count_done(0, FRAME + 9);
    n_checks++; if (e !== 1) $display("FAIL basic_done_count got=%0d exp=1", e); else n_pass++;
    idle_gap();
  endtask

  task automatic test_snapshot();
    int e;
    nt = 24'h000000;
    nd = 32'h31122024;
    start_frame(24'h235959, 32'h31122024);
    capture(0, FRAME + 4, -1, 0);
    e = decode_errs(0, 24'h235959, 32'h31122024);
    n_checks++; if (e !== 0) $display("FAIL snapshot_chars bad=%0d exp=0", e); else n_pass++;
    e = wave_errs(0, 24'h235959, 32'h31122024);
    n_checks++; if (e !== 0) $display("FAIL snapshot_wave bad_cycles=%0d exp=0", e); else n_pass++;
    idle_gap();
  endtask

  task automatic test_busy_reject();
    int e;
    start_frame(24'h101010, 32'h05062021);
    capture(0, FRAME + 40, 99, -1);
    e = count_done(0, FRAME + 39);
    n_checks++; if (e !== 1) $display("FAIL reject_done_count got=%0d exp=1", e); else n_pass++;
    e = count_busy(0, FRAME + 39);
    n_checks++; if (e !== FRAME) $display("FAIL reject_busy_len got=%0d exp=%0d", e, FRAME); else n_pass++;
    e = wave_errs(0, 24'h101010, 32'h05062021);
    n_checks++; if (e !== 0) $display("FAIL reject_wave bad_cycles=%0d exp=0", e); else n_pass++;
    idle_gap();
  endtask

  task automatic test_invalid_digit();
    int e;
    start_frame(24'hA00000, 32'h01012000);
    capture(0, FRAME + 4, -1, -1);
    decode(0);
    n_checks++; if (dec_bytes[0] !== 8'h3F) $display("FAIL invalid_char0 got=%h exp=3f", dec_bytes[0]); else n_pass++;
    n_checks++; if (dec_bytes[1] !== 8'h30) $display("FAIL invalid_char1 got=%h exp=30", dec_bytes[1]); else n_pass++;
    e = wave_errs(0, 24'hA00000, 32'h01012000);
    n_checks++; if (e !== 0) $display("FAIL invalid_wave bad_cycles=%0d exp=0", e); else n_pass++;
    idle_gap();
  endtask

  task automatic test_back_to_back();
    int e;
    nt = 24'h084512;
    nd = 32'h29021996;
    start_frame(24'h120000, 32'h15081947);
    capture(0, 2 * FRAME + 10, FRAME, 5);
    n_checks++; if (done_log[FRAME] !== 1'b1) $display("FAIL b2b_done1 got=%b exp=1", done_log[FRAME]); else n_pass++;
    n_checks++; if (tx_log[FRAME+1] !== 1'b0 || busy_log[FRAME+1] !== 1'b1)
      $display("FAIL b2b_restart got tx=%b busy=%b exp tx=0 busy=1", tx_log[FRAME+1], busy_log[FRAME+1]); else n_pass++;
    e = wave_errs(0, 24'h120000, 32'h15081947);
    n_checks++; if (e !== 0) $display("FAIL b2b_wave1 bad_cycles=%0d exp=0", e); else n_pass++;
    e = wave_errs(FRAME + 1, 24'h084512, 32'h29021996);
    n_checks++; if (e !== 0) $display("FAIL b2b_wave2 bad_cycles=%0d exp=0", e); else n_pass++;
    e = count_done(0, 2 * FRAME + 9);
    n_checks++; if (e !== 2) $display("FAIL b2b_done_count got=%0d exp=2", e); else n_pass++;
    idle_gap();
  endtask

  task automatic test_mid_reset();
    int e;
    start_frame(24'h235959, 32'h31122024);
    capture(0, 500, -1, -1);
    rst = 1'b1;
    #1;
    n_checks++; if (bus.tx !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL midrst_immediate got tx=%b busy=%b exp tx=1 busy=0", bus.tx, bus.busy); else n_pass++;
    capture(500, 4, -1, -1);
    @(negedge clk);
    rst = 1'b0;
    capture(504, 20, -1, -1);
    e = count_done(500, 523);
    n_checks++; if (e !== 0) $display("FAIL midrst_no_done got=%0d exp=0", e); else n_pass++;
    e = count_busy(500, 523);
    n_checks++; if (e !== 0) $display("FAIL midrst_busy got=%0d exp=0", e); else n_pass++;
    start_frame(24'h070809, 32'h10111999);
    capture(0, FRAME + 4, -1, -1);
    e = wave_errs(0, 24'h070809, 32'h10111999);
    n_checks++; if (e !== 0) $display("FAIL midrst_refr_wave bad_cycles=%0d exp=0", e); else n_pass++;
    e = count_done(0, FRAME + 3);
    n_checks++; if (e !== 1) $display("FAIL midrst_refr_done got=%0d exp=1", e); else n_pass++;
    idle_gap();
  endtask

  task automatic test_random();
    logic [23:0] t;
    logic [31:0] d;
    int e;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) t[i*4 +: 4] = rnd_digit();
      for (int i = 0; i < 8; i++) d[i*4 +: 4] = rnd_digit();
      start_frame(t, d);
      capture(0, FRAME + 4, -1, -1);
      e = decode_errs(0, t, d);
      n_checks++; if (e !== 0) $display("FAIL rand%0d_chars t=%h d=%h bad=%0d exp=0", r, t, d, e); else n_pass++;
      e = wave_errs(0, t, d);
      n_checks++; if (e !== 0) $display("FAIL rand%0d_wave bad_cycles=%0d exp=0", r, e); else n_pass++;
      e = count_done(0, FRAME + 3);
      n_checks++; if (e !== 1) $display("FAIL rand%0d_done got=%0d exp=1", r, e); else n_pass++;
      idle_gap();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_snapshot();
    test_busy_reject();
    test_invalid_digit();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
